id_stage_hz: RTL and testbench
==============================

ID_STAGE_HZ -- requirements
Module: id_stage_hz

Interface
REQ-001 Parameter DATA_W, default 32, register/datapath width in bits.
REQ-002 Parameter REG_ADDR_W, default 5, register address width; register count = 2**REG_ADDR_W.
REQ-003 Parameter IMM_W, default 16, immediate field width (instr[IMM_W-1:0]), sign-extended to DATA_W.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 wb_reg_write  in  1  write-back enable.
REQ-007 wb_write_reg_location  in  REG_ADDR_W  write-back destination register.
REQ-008 mem_wb_write_data  in  DATA_W  write-back data.
REQ-009 if_id_instr  in  32  instruction from IF/ID: op[31:26], rs[25:21], rt[20:16], rd[15:11].
REQ-010 if_id_npc  in  DATA_W  next PC from IF/ID.
REQ-011 id_flush  in  1  kill the instruction currently in ID (branch taken).
REQ-012 id_stall  out  1  load-use hazard; upstream holds PC and IF/ID.
REQ-013 id_ex_wb  out  2  {RegWrite, MemToReg}.
REQ-014 id_ex_mem  out  3  {Branch, MemRead, MemWrite}.
REQ-015 id_ex_execute  out  4  {RegDst, ALUOp[1:0], ALUSrc}.
REQ-016 id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext  out  DATA_W each  registered datapath values.
REQ-017 id_ex_rs, id_ex_rt, id_ex_rd  out  REG_ADDR_W each  registered register fields (rs for forwarding unit).

Function
REQ-018 Register file SHALL hold 2**REG_ADDR_W x DATA_W entries; register 0 SHALL read 0 and ignore writes.
REQ-019 Write SHALL occur at rising edge when wb_reg_write=1 and wb_write_reg_location!=0.
REQ-020 Reads SHALL be combinational with write-through: same-cycle write to a read address returns mem_wb_write_data.
REQ-021 Decode (wb/mem/ex): op 0x00 R-type 10/000/1100; 0x23 lw 11/010/0001; 0x2B sw 00/001/0001; 0x04 beq 00/100/0010; 0x08 addi 10/000/0001; any other opcode all zeros.
REQ-022 Hazard = id_ex_mem[1] & (id_ex_rt!=0) & (id_ex_rt==rs | id_ex_rt==rt) of if_id_instr; combinational.
REQ-023 id_stall SHALL equal hazard & ~id_flush.
REQ-024 ID/EX register SHALL update every rising edge (latency 1 cycle); no enable.
REQ-025 On id_stall=1 or id_flush=1, wb/mem/execute SHALL load zeros (bubble); datapath fields load normally.
REQ-026 Simultaneous flush and hazard: bubble inserted, id_stall=0.
REQ-027 Sign extension SHALL replicate instr[IMM_W-1] into bits DATA_W-1:IMM_W.

Reset
REQ-028 rst=1 SHALL immediately clear all ID/EX outputs and all registers to 0, including mid-stall; id_stall then evaluates 0.
REQ-029 First rising edge after rst deassert SHALL capture normally.

Structure
REQ-030 Opcode constants, control-bit field positions and control-word widths SHALL live in shared package id_pkg.
REQ-031 Register file SHALL be sub-module regfile_wt (parametrised DATA_W, REG_ADDR_W); decode, hazard and ID/EX register stay inline.

Verification
REQ-032 Write r5=0x1234 via WB, then decode add r6,r5,r5 -> next cycle id_ex_readdat1=id_ex_readdat2=0x00001234, id_ex_wb=10.
REQ-033 Same-cycle WB write r7=0xCAFE and decode reading r7 -> id_ex_readdat1=0x0000CAFE.
REQ-034 lw r8 into EX, next instr uses rs=r8 -> id_stall=1 one cycle, ID/EX controls=0; held instr then issues with correct controls.
REQ-035 lw r0 followed by use of r0 -> id_stall=0; write to r0 -> reads 0.
REQ-036 addi imm=0x8000 -> id_ex_sign_ext=0xFFFF8000; id_flush=1 same cycle -> controls 0.
REQ-037 Assert rst during stall -> all outputs 0 asynchronously, id_stall=0; repeat with DATA_W=64, REG_ADDR_W=6.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control-word widths and
// control-bit positions within the WB / MEM / EX groups.
package id_pkg;

    localparam int WB_W  = 2;
    localparam int MEM_W = 3;
    localparam int EX_W  = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;
    localparam int MEM_BRANCH    = 2;
    localparam int MEM_MEM_READ  = 1;
    localparam int MEM_MEM_WRITE = 0;
    localparam int EX_REG_DST    = 3;
    localparam int EX_ALU_OP_HI  = 2;
    localparam int EX_ALU_OP_LO  = 1;
    localparam int EX_ALU_SRC    = 0;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  ex;
    } ctrl_t;

    // Unknown opcodes decode to an all-zero (harmless) control word.
    function automatic ctrl_t decode_op(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.wb[WB_REG_WRITE]                = 1'b1;
                c.ex[EX_REG_DST]                  = 1'b1;
                c.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]   = 2'b10;
            end
            OP_LW: begin
                c.wb[WB_REG_WRITE]                = 1'b1;
                c.wb[WB_MEM_TO_REG]               = 1'b1;
                c.mem[MEM_MEM_READ]               = 1'b1;
                c.ex[EX_ALU_SRC]                  = 1'b1;
            end
            OP_SW: begin
                c.mem[MEM_MEM_WRITE]              = 1'b1;
                c.ex[EX_ALU_SRC]                  = 1'b1;
            end
            OP_BEQ: begin
                c.mem[MEM_BRANCH]                 = 1'b1;
                c.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]   = 2'b01;
            end
            OP_ADDI: begin
                c.wb[WB_REG_WRITE]                = 1'b1;
                c.ex[EX_ALU_SRC]                  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_hz_if.sv
// Bundle between IF/ID, write-back and the ID stage; master drives the stage
// inputs, slave is the ID stage itself.
interface id_stage_hz_if
    import id_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_write_reg_location;
    logic [DATA_W-1:0]     mem_wb_write_data;
    logic [31:0]           if_id_instr;
    logic [DATA_W-1:0]     if_id_npc;
    logic                  id_flush;
    logic                  id_stall;
    logic [WB_W-1:0]       id_ex_wb;
    logic [MEM_W-1:0]      id_ex_mem;
    logic [EX_W-1:0]       id_ex_execute;
    logic [DATA_W-1:0]     id_ex_npc;
    logic [DATA_W-1:0]     id_ex_readdat1;
    logic [DATA_W-1:0]     id_ex_readdat2;
    logic [DATA_W-1:0]     id_ex_sign_ext;
    logic [REG_ADDR_W-1:0] id_ex_rs;
    logic [REG_ADDR_W-1:0] id_ex_rt;
    logic [REG_ADDR_W-1:0] id_ex_rd;

    modport master (
        output wb_reg_write, wb_write_reg_location, mem_wb_write_data,
               if_id_instr, if_id_npc, id_flush,
        input  id_stall, id_ex_wb, id_ex_mem, id_ex_execute, id_ex_npc,
               id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext,
               id_ex_rs, id_ex_rt, id_ex_rd
    );

    modport slave (
        input  wb_reg_write, wb_write_reg_location, mem_wb_write_data,
               if_id_instr, if_id_npc, id_flush,
        output id_stall, id_ex_wb, id_ex_mem, id_ex_execute, id_ex_npc,
               id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext,
               id_ex_rs, id_ex_rt, id_ex_rd
    );
endinterface

// File: rtl/regfile_wt.sv
// Register file with two combinational read ports and write-through: a read of
// the register being written this cycle returns the incoming write data.
module regfile_wt #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);
    localparam int NREGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_live;

    // Register 0 is hard-wired to zero, so writes to it are dropped here.
    assign wr_live = we && (waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (wr_live && waddr == raddr1) rdata1 = wdata;
        if (wr_live && waddr == raddr2) rdata2 = wdata;
        if (raddr1 == '0) rdata1 = '0;
        if (raddr2 == '0) rdata2 = '0;
    end
endmodule

// File: rtl/id_stage_hz.sv
// Instruction decode stage: register read, control decode, load-use hazard
// detection and the ID/EX pipeline register.
module id_stage_hz
    import id_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_stage_hz_if.slave  bus
);
    logic [REG_ADDR_W-1:0]    rs_p0, rt_p0, rd_p0;
    logic [DATA_W-1:0]        rdata1_p0, rdata2_p0;
    logic signed [DATA_W-1:0] sext_p0;
    logic                     hazard_p0, bubble_p0;
    ctrl_t                    ctrl_p0;

    ctrl_t                    ctrl_p1;
    logic [DATA_W-1:0]        npc_p1, rdata1_p1, rdata2_p1;
    logic signed [DATA_W-1:0] sext_p1;
    logic [REG_ADDR_W-1:0]    rs_p1, rt_p1, rd_p1;

    function automatic logic signed [DATA_W-1:0] sign_extend(input logic signed [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // ---- ID (p0): decode, register read, hazard ----
    assign rs_p0   = REG_ADDR_W'(bus.if_id_instr[25:21]);
    assign rt_p0   = REG_ADDR_W'(bus.if_id_instr[20:16]);
    assign rd_p0   = REG_ADDR_W'(bus.if_id_instr[15:11]);
    assign sext_p0 = sign_extend(bus.if_id_instr[IMM_W-1:0]);

    regfile_wt #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_reg_write),
        .waddr  (bus.wb_write_reg_location),
        .wdata  (bus.mem_wb_write_data),
        .raddr1 (rs_p0),
        .raddr2 (rt_p0),
        .rdata1 (rdata1_p0),
        .rdata2 (rdata2_p0)
    );

    // A load in EX whose destination feeds this instruction must wait one cycle.
    assign hazard_p0 = ctrl_p1.mem[MEM_MEM_READ] && (rt_p1 != '0) &&
                       ((rt_p1 == rs_p0) || (rt_p1 == rt_p0));
    // A flush kills the instruction anyway, so there is nothing left to hold.
    assign bus.id_stall = hazard_p0 & ~bus.id_flush;
    assign bubble_p0    = hazard_p0 | bus.id_flush;
    assign ctrl_p0      = bubble_p0 ? '0 : decode_op(bus.if_id_instr[31:26]);

    // ---- ID/EX register (p1) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_p1   <= '0;
            npc_p1    <= '0;
            rdata1_p1 <= '0;
            rdata2_p1 <= '0;
            sext_p1   <= '0;
            rs_p1     <= '0;
            rt_p1     <= '0;
            rd_p1     <= '0;
        end else begin
            ctrl_p1   <= ctrl_p0;
            npc_p1    <= bus.if_id_npc;
            rdata1_p1 <= rdata1_p0;
            rdata2_p1 <= rdata2_p0;
            sext_p1   <= sext_p0;
            rs_p1     <= rs_p0;
            rt_p1     <= rt_p0;
            rd_p1     <= rd_p0;
        end
    end

    assign bus.id_ex_wb       = ctrl_p1.wb;
    assign bus.id_ex_mem      = ctrl_p1.mem;
    assign bus.id_ex_execute  = ctrl_p1.ex;
    assign bus.id_ex_npc      = npc_p1;
    assign bus.id_ex_readdat1 = rdata1_p1;
    assign bus.id_ex_readdat2 = rdata2_p1;
    assign bus.id_ex_sign_ext = sext_p1;
    assign bus.id_ex_rs       = rs_p1;
    assign bus.id_ex_rt       = rt_p1;
    assign bus.id_ex_rd       = rd_p1;
endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: decode table, directed hazard/flush/reset sequences,
// then random traffic against a behavioural model; second instance at 64/6.
module tb_id_stage_hz;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_stage_hz_if #(.DATA_W(32), .REG_ADDR_W(5)) b  ();
    id_stage_hz_if #(.DATA_W(64), .REG_ADDR_W(6)) b2 ();

    id_stage_hz #(.DATA_W(32), .REG_ADDR_W(5), .IMM_W(16)) dut (
        .clk (clk), .rst (rst), .bus (b.slave));
    id_stage_hz #(.DATA_W(64), .REG_ADDR_W(6), .IMM_W(16)) dut64 (
        .clk (clk), .rst (rst), .bus (b2.slave));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ex;
        logic [31:0] se;
    } vec_t;
    vec_t vt [7];

    // Reference control words {RegWrite,MemToReg, Branch,MemRead,MemWrite, RegDst,ALUOp,ALUSrc}
    logic [5:0] ref_ops   [5] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
    logic [8:0] ref_words [5] = '{9'b10_000_1100, 9'b11_010_0001, 9'b00_001_0001,
                                  9'b00_100_0010, 9'b10_000_0001};

    logic [31:0] mregs [32];
    logic [1:0]  e_wb;
    logic [2:0]  e_mem;
    logic [3:0]  e_ex;
    logic [31:0] e_npc, e_rd1, e_rd2, e_se;
    logic [4:0]  e_rs, e_rt, e_rd;

    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        for (int i = 0; i < 5; i++) if (ref_ops[i] == op) return ref_words[i];
        return 9'b0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 11'h000};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] npc, input logic flush,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        b.if_id_instr           = instr;
        b.if_id_npc             = npc;
        b.id_flush              = flush;
        b.wb_reg_write          = we;
        b.wb_write_reg_location = wa;
        b.mem_wb_write_data     = wd;
    endtask

    task automatic chk_ctrl(input string name, input logic [8:0] exp);
        chk(name, {b.id_ex_wb, b.id_ex_mem, b.id_ex_execute}, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {b.id_ex_wb, b.id_ex_mem, b.id_ex_execute}, 0);
        chk({tag, "_npc"},  b.id_ex_npc, 0);
        chk({tag, "_rd1"},  b.id_ex_readdat1, 0);
        chk({tag, "_rd2"},  b.id_ex_readdat2, 0);
        chk({tag, "_se"},   b.id_ex_sign_ext, 0);
        chk({tag, "_regs"}, {b.id_ex_rs, b.id_ex_rt, b.id_ex_rd}, 0);
        chk({tag, "_stall"}, b.id_stall, 0);
    endtask

    task automatic chk_zero64(input string tag);
        chk({tag, "_ctrl"}, {b2.id_ex_wb, b2.id_ex_mem, b2.id_ex_execute}, 0);
        chk({tag, "_npc"},  b2.id_ex_npc, 0);
        chk({tag, "_rd1"},  b2.id_ex_readdat1, 0);
        chk({tag, "_rd2"},  b2.id_ex_readdat2, 0);
        chk({tag, "_se"},   b2.id_ex_sign_ext, 0);
        chk({tag, "_regs"}, {b2.id_ex_rs, b2.id_ex_rt, b2.id_ex_rd}, 0);
        chk({tag, "_stall"}, b2.id_stall, 0);
    endtask

    initial begin
        logic [31:0] cur;
        logic [5:0]  op;
        logic [4:0]  rs, rt, wa;
        logic [31:0] wd, np;
        logic        fl, we, haz, held;
        logic [8:0]  ctl;

        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        b2.if_id_instr = 32'h0; b2.if_id_npc = 64'h0; b2.id_flush = 1'b0;
        b2.wb_reg_write = 1'b0; b2.wb_write_reg_location = 6'd0; b2.mem_wb_write_data = 64'h0;

        vt[0] = '{rtype(5'd1, 5'd2, 5'd3),              2'b10, 3'b000, 4'b1100, 32'h0000_1800};
        vt[1] = '{itype(6'h23, 5'd1, 5'd0, 16'h0010),   2'b11, 3'b010, 4'b0001, 32'h0000_0010};
        vt[2] = '{itype(6'h2B, 5'd1, 5'd2, 16'hFFFC),   2'b00, 3'b001, 4'b0001, 32'hFFFF_FFFC};
        vt[3] = '{itype(6'h04, 5'd3, 5'd4, 16'h0003),   2'b00, 3'b100, 4'b0010, 32'h0000_0003};
        vt[4] = '{itype(6'h08, 5'd0, 5'd5, 16'h7FFF),   2'b10, 3'b000, 4'b0001, 32'h0000_7FFF};
        vt[5] = '{itype(6'h3F, 5'd1, 5'd1, 16'h1234),   2'b00, 3'b000, 4'b0000, 32'h0000_1234};
        vt[6] = '{itype(6'h02, 5'd0, 5'd0, 16'h9000),   2'b00, 3'b000, 4'b0000, 32'hFFFF_9000};

        // Reset state
        #2 rst = 1'b1;
        #1 chk_zero("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // Decode table; the first entry also proves the first edge after reset captures
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].instr, 32'h100 + 32'(i) * 4, 1'b0, 1'b0, 5'd0, 32'h0);
            #2 chk("tbl_stall", b.id_stall, 1'b0);
            tick();
            chk($sformatf("tbl%0d_ctrl", i), {b.id_ex_wb, b.id_ex_mem, b.id_ex_execute},
                {vt[i].wb, vt[i].mem, vt[i].ex});
            chk($sformatf("tbl%0d_se", i), b.id_ex_sign_ext, vt[i].se);
            chk($sformatf("tbl%0d_npc", i), b.id_ex_npc, 32'h100 + 32'(i) * 4);
        end

        // Write r5 then read it twice
        drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
        tick();
        drive(rtype(5'd5, 5'd5, 5'd6), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("wb_r5_rd1", b.id_ex_readdat1, 32'h0000_1234);
        chk("wb_r5_rd2", b.id_ex_readdat2, 32'h0000_1234);
        chk("wb_r5_wb",  b.id_ex_wb, 2'b10);

        // Write-through on the same cycle
        drive(rtype(5'd7, 5'd0, 5'd9), 32'h0, 1'b0, 1'b1, 5'd7, 32'hCAFE);
        tick();
        chk("wt_r7_rd1", b.id_ex_readdat1, 32'h0000_CAFE);

        // Load-use stall: one bubble, then the held instruction issues
        drive(itype(6'h23, 5'd1, 5'd8, 16'h0004), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk_ctrl("lw_ctrl", 9'b11_010_0001);
        drive(rtype(5'd8, 5'd2, 5'd3), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        #2 chk("lu_stall", b.id_stall, 1'b1);
        tick();
        chk_ctrl("lu_bubble", 9'b0);
        chk("lu_bubble_rs", b.id_ex_rs, 5'd8);
        #2 chk("lu_release", b.id_stall, 1'b0);
        tick();
        chk_ctrl("lu_issue", 9'b10_000_1100);

        // lw to r0 never stalls; r0 ignores writes even with a same-cycle read
        drive(itype(6'h23, 5'd1, 5'd0, 16'h0000), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        drive(rtype(5'd0, 5'd0, 5'd3), 32'h0, 1'b0, 1'b1, 5'd0, 32'hFFFF);
        #2 chk("r0_nostall", b.id_stall, 1'b0);
        tick();
        chk("r0_wt_rd1", b.id_ex_readdat1, 32'h0);
        drive(rtype(5'd0, 5'd0, 5'd4), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("r0_rd1", b.id_ex_readdat1, 32'h0);

        // Negative immediate, then the same instruction flushed
        drive(itype(6'h08, 5'd0, 5'd1, 16'h8000), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("addi_se", b.id_ex_sign_ext, 32'hFFFF_8000);
        chk_ctrl("addi_ctrl", 9'b10_000_0001);
        drive(itype(6'h08, 5'd0, 5'd1, 16'h8000), 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        tick();
        chk_ctrl("flush_ctrl", 9'b0);
        chk("flush_se", b.id_ex_sign_ext, 32'hFFFF_8000);

        // Flush coinciding with a load-use hazard: bubble, no stall
        drive(itype(6'h23, 5'd1, 5'd8, 16'h0000), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        drive(rtype(5'd2, 5'd8, 5'd3), 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        #2 chk("fh_stall", b.id_stall, 1'b0);
        tick();
        chk_ctrl("fh_ctrl", 9'b0);

        // Random traffic against the model, starting from a clean reset
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        e_wb = '0; e_mem = '0; e_ex = '0; e_npc = '0; e_rd1 = '0; e_rd2 = '0; e_se = '0;
        e_rs = '0; e_rt = '0; e_rd = '0;
        held = 1'b0;
        cur  = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                int k;
                k  = int'($urandom % 6);
                op = (k < 5) ? ref_ops[k] : 6'($urandom);
                cur = {op, 5'($urandom % 8), 5'($urandom % 8), 16'($urandom)};
            end
            fl = (($urandom % 8) == 0);
            we = 1'($urandom);
            wa = 5'($urandom % 8);
            wd = $urandom;
            np = $urandom;
            drive(cur, np, fl, we, wa, wd);
            #2;
            rs  = cur[25:21];
            rt  = cur[20:16];
            haz = e_mem[1] && (e_rt != 5'd0) && (e_rt == rs || e_rt == rt);
            chk("rnd_stall", b.id_stall, haz && !fl);
            held = haz && !fl;
            ctl  = (haz || fl) ? 9'b0 : ref_ctrl(cur[31:26]);
            {e_wb, e_mem, e_ex} = ctl;
            e_rd1 = ref_read(rs, we, wa, wd);
            e_rd2 = ref_read(rt, we, wa, wd);
            e_se  = {{16{cur[15]}}, cur[15:0]};
            e_npc = np;
            e_rs  = rs;
            e_rt  = rt;
            e_rd  = cur[15:11];
            if (we && wa != 5'd0) mregs[wa] = wd;
            tick();
            chk("rnd_ctrl", {b.id_ex_wb, b.id_ex_mem, b.id_ex_execute}, {e_wb, e_mem, e_ex});
            chk("rnd_rd1", b.id_ex_readdat1, e_rd1);
            chk("rnd_rd2", b.id_ex_readdat2, e_rd2);
            chk("rnd_se",  b.id_ex_sign_ext, e_se);
            chk("rnd_npc", b.id_ex_npc, e_npc);
            chk("rnd_regs", {b.id_ex_rs, b.id_ex_rt, b.id_ex_rd}, {e_rs, e_rt, e_rd});
        end

        // 64-bit / 64-register instance: write, read, sign extension
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        b2.wb_reg_write = 1'b1; b2.wb_write_reg_location = 6'd5;
        b2.mem_wb_write_data = 64'h0123_4567_89AB_CDEF;
        tick();
        b2.wb_reg_write = 1'b0;
        b2.if_id_instr = itype(6'h08, 5'd5, 5'd0, 16'h8000);
        tick();
        chk("w64_rd1", b2.id_ex_readdat1, 64'h0123_4567_89AB_CDEF);
        chk("w64_se",  b2.id_ex_sign_ext, 64'hFFFF_FFFF_FFFF_8000);

        // Reset asserted in the middle of a stall, on both widths
        drive(itype(6'h23, 5'd1, 5'd8, 16'h0000), 32'h40, 1'b0, 1'b0, 5'd0, 32'h0);
        b2.if_id_instr = itype(6'h23, 5'd1, 5'd8, 16'h0000);
        tick();
        drive(rtype(5'd8, 5'd2, 5'd3), 32'h44, 1'b0, 1'b0, 5'd0, 32'h0);
        b2.if_id_instr = rtype(5'd8, 5'd2, 5'd3);
        #1;
        chk("rs_pre_stall",   b.id_stall, 1'b1);
        chk("rs_pre_stall64", b2.id_stall, 1'b1);
        rst = 1'b1;
        #1;
        chk_zero("rst_stall");
        chk_zero64("rst_stall64");
        @(posedge clk);
        #2 rst = 1'b0;
        drive(rtype(5'd5, 5'd7, 5'd0), 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        b2.if_id_instr = rtype(5'd5, 5'd0, 5'd0);
        tick();
        chk("post_rst_r5",   b.id_ex_readdat1, 32'h0);
        chk("post_rst_r7",   b.id_ex_readdat2, 32'h0);
        chk("post_rst_r5_64", b2.id_ex_readdat1, 64'h0);
        chk_ctrl("post_rst_ctrl", 9'b10_000_1100);
        chk("post_rst_ctrl64", {b2.id_ex_wb, b2.id_ex_mem, b2.id_ex_execute}, 9'b10_000_1100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
